// File: rtl/seq_sub_nibble_pkg.sv
// Shared definitions for the nibble-serial subtractor.
//   state_t    : controller states (IDLE, RUN, DONE)
//   NIBBLE_W   : width of one arithmetic slice
//   idx_width  : width of the nibble index, clog2(n) with a floor of 1
package seq_sub_nibble_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_sub_nibble_sub4.sv
// Combinational 4-bit ripple-borrow subtractor: {bo, d} = a - b - bi.
// Ports:
//   a, b : 4-bit minuend / subtrahend
//   bi   : borrow in
//   d    : 4-bit difference
//   bo   : borrow out of bit 3
module seq_sub_nibble_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo
);

    logic [4:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bi;
        for (int i = 0; i < 4; i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            // borrow when a<b at this bit, or equal bits with a pending borrow
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
        bo = br[4];
    end

endmodule

// File: rtl/seq_sub_nibble.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock through a
// single shared 4-bit slice. The inter-nibble borrow lives in borrow_reg.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, bin            : operands and borrow-in
//   out_valid / out_ready: result handshake (valid only in DONE)
//   diff, borrow         : result and final borrow
//   zero, neg, ovf       : flags registered when the last nibble completes
module seq_sub_nibble
    import seq_sub_nibble_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b,
    input  logic                          bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   diff,
    output logic                          borrow,
    output logic                          zero,
    output logic                          neg,
    output logic                          ovf
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t                state, state_nx;
    logic [IW-1:0]         idx;
    logic [W-1:0]          a_reg, b_reg, diff_reg, diff_nx;
    logic                  borrow_reg;
    logic                  borrow_q, zero_q, neg_q, ovf_q;
    logic [NIBBLE_W-1:0]   a_nib, b_nib, d_nib;
    logic                  bo_nib;
    logic                  accept, run, last;

    // Nibble select by index; explicit mux keeps widths clean.
    always_comb begin
        a_nib   = '0;
        b_nib   = '0;
        diff_nx = diff_reg;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
                diff_nx[i*NIBBLE_W +: NIBBLE_W] = d_nib;
            end
        end
    end

    seq_sub_nibble_sub4 u_sub4 (
        .a  (a_nib),
        .b  (b_nib),
        .bi (borrow_reg),
        .d  (d_nib),
        .bo (bo_nib)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (idx == LAST) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = (state == IDLE) & in_valid;
    assign run    = (state == RUN);
    assign last   = (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            borrow_q   <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            idx        <= '0;
        end else if (run) begin
            diff_reg   <= diff_nx;
            borrow_reg <= bo_nib;
            if (last) begin
                // flags use the merged diff, which includes this last nibble
                borrow_q <= bo_nib;
                zero_q   <= (diff_nx == '0);
                neg_q    <= diff_nx[W-1];
                ovf_q    <= (a_reg[W-1] ^ b_reg[W-1]) & (diff_nx[W-1] ^ a_reg[W-1]);
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Final borrow kept apart from borrow_reg so it survives a new accept's bin load.
    assign diff   = diff_reg;
    assign borrow = borrow_q;
    assign zero   = zero_q;
    assign neg    = neg_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_sub_nibble.sv
module tb_seq_sub_nibble;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] a, b;
    logic       bin;
    logic       out_valid, out_ready;
    logic [7:0] diff;
    logic       borrow, zero, neg, ovf;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       zero;
        logic       neg;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        exp_t       e;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];

    seq_sub_nibble #(.NIBBLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin);
        exp_t e;
        logic [8:0] t;
        t        = {1'b0, ta} - {1'b0, tb_} - {8'd0, tbin};
        e.diff   = t[7:0];
        e.borrow = t[8];
        e.zero   = (t[7:0] == 8'd0);
        e.neg    = t[7];
        e.ovf    = (ta[7] ^ tb_[7]) & (t[7] ^ ta[7]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid, bounded; returns cycles elapsed since the accept edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, "_valid"},  32'(out_valid), 32'd1);
            chk({tag, "_diff"},   32'(diff),      32'(e.diff));
            chk({tag, "_borrow"}, 32'(borrow),    32'(e.borrow));
            chk({tag, "_zero"},   32'(zero),      32'(e.zero));
            chk({tag, "_neg"},    32'(neg),       32'(e.neg));
            chk({tag, "_ovf"},    32'(ovf),       32'(e.ovf));
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tbin, input exp_t e);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sbq.push_back(e);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        out_ready = 1'b1;
        pop_cmp(tag);
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb;
        logic       rbin;

        vecs[0] = '{8'h3C, 8'h15, 1'b0, '{8'h27, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{8'h00, 8'h01, 1'b0, '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[2] = '{8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[3] = '{8'h10, 8'h0F, 1'b1, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[4] = '{8'h5A, 8'h5A, 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1}};
        vecs[7] = '{8'h00, 8'h00, 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;

        // reset
        tick(); tick();
        chk("rst_valid",  32'(out_valid), 32'd0);
        chk("rst_diff",   32'(diff),      32'd0);
        chk("rst_borrow", 32'(borrow),    32'd0);
        chk("rst_zero",   32'(zero),      32'd0);
        chk("rst_neg",    32'(neg),       32'd0);
        chk("rst_ovf",    32'(ovf),       32'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // table vectors
        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e);

        // random vectors against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            do_op($sformatf("rnd%0d", i), ra, rb, rbin, model(ra, rb, rbin));
        end

        // backpressure: held result, new operands ignored until IDLE
        a = 8'h3C; b = 8'h15; bin = 1'b0; in_valid = 1'b1;
        tick();
        sbq.push_back(model(8'h3C, 8'h15, 1'b0));
        a = 8'hAA; b = 8'h11; bin = 1'b0;
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready),  32'd0);
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_diff",     32'(diff),      32'h27);
        end
        out_ready = 1'b1;
        pop_cmp("bp_first");
        tick();
        chk("bp_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        sbq.push_back(model(8'hAA, 8'h11, 1'b0));
        wait_valid(lat);
        chk("bp2_latency", 32'(lat), 32'd2);
        out_ready = 1'b1;
        pop_cmp("bp_second");
        chk("bp2_diff_const", 32'(diff), 32'h99);
        tick();
        out_ready = 1'b0;

        // abort mid-RUN
        a = 8'hFF; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_valid",  32'(out_valid), 32'd0);
        chk("ab_diff",   32'(diff),      32'd0);
        chk("ab_borrow", 32'(borrow),    32'd0);
        chk("ab_flags",  32'({zero, neg, ovf}), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ab_no_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        do_op("ab_next", 8'h05, 8'h07, 1'b0, '{8'hFE, 1'b1, 1'b0, 1'b1, 1'b0});

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
